encoder_8_3_serial: RTL
=======================

Name: encoder_8_3_serial

Overview:
- Return-direction counterpart of the 3:8 decoder: takes an 8-bit request vector and emits the 3-bit binary index of every set bit, one index per beat, lowest index first.
- Sits behind request/flag collectors; feeds index streams back into decode/dispatch logic.
- Valid/ready handshake on both sides; single clock domain; registered outputs.

Parameters:
- VEC_W, 8, width of input vector (fixed at 8 for this revision)
- IDX_W, 3, width of output index; must equal clog2(VEC_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec presented
- in_ready  output  1  block can accept a vector
- in_vec  input  8  request vector, bit i set = index i requested
- out_valid  output  1  out_idx/out_last valid
- out_ready  input  1  consumer accepts current beat
- out_idx  output  3  binary index of lowest pending set bit
- out_last  output  1  current beat is the final one for this vector
- busy  output  1  vector in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, busy=0.
- States: IDLE, DRAIN.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - in_vec==0: vector consumed, no output beat, stay IDLE.
  - in_vec!=0: pending<=in_vec, go DRAIN.
- DRAIN: in_ready=0, busy=1, out_valid=1.
  - out_idx = index of lowest set bit of pending.
  - out_last = 1 when pending has exactly one set bit.
- Beat transfer on out_valid&&out_ready: clear that bit in pending. If out_last, then pending becomes 0 and the next state is IDLE.
- Stall (out_ready=0): out_idx, out_last, out_valid held stable; pending unchanged.
- Latency: first beat valid the cycle after acceptance. Vector with N set bits takes N beats plus 1 IDLE cycle before the next acceptance.
- No combinational path from in_* or out_ready to out_valid/out_idx/out_last. These outputs derive from registers only. in_ready depends on state only.
- in_vec is ignored while in DRAIN.
- Reset mid-DRAIN: remaining bits are discarded; outputs return to reset values immediately.
- in_vec=8'hFF produces 8 beats, idx 0..7, with out_last only on idx 7.

Optional Feature:
- Macro: ENCODER_COUNT_EN
- Defined: adds output port out_cnt [3:0].
  - Popcount of the accepted vector, registered at acceptance.
  - Held through DRAIN; reset 0.
  - Zero vectors update it to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package enc_pkg:
  - ENC_VEC_W=8, ENC_IDX_W=3
  - state typedef enc_state_t {IDLE, DRAIN}
  - ENC_CNT_W=4
- Sub-module ffs_encode_8 (combinational): 8-bit vector -> lowest-set-bit index [2:0] plus found flag. Instantiated once on pending.
- FSM, pending register and handshake stay in the top module.

Test Plan:
- Reset check: rst_n=0 mid-simulation -> out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1 asynchronously.
- Single bit: in_vec=8'b00100000 accepted, out_ready=1 -> one beat with idx=5, last=1; in_ready=1 again 2 cycles after acceptance.
- Multi-bit with stalls: in_vec=8'b10010010, out_ready toggling 1,0,0,1,... -> idx sequence 1,4,7, last only on 7, outputs stable during stalls, in_ready=0 throughout.
- Zero vector: in_vec=0 with in_valid=1 -> no out_valid pulse, stays IDLE. A following 8'h01 is accepted next cycle -> idx=0, last=1.
- Full vector plus back-to-back input: 8'hFF, then 8'h80 held valid -> 8 beats idx 0..7; 8'h80 accepted only after return to IDLE; then idx=7, last=1. With ENCODER_COUNT_EN: out_cnt=8, then 1.
- Reset mid-drain: 8'b00001111, rst_n pulsed after 2 beats -> no further beats; the next vector 8'b01000000 yields a single idx=6.

Source files
------------

// File: rtl/encoder_8_3_serial_pkg.sv
// Shared types and constants for the serial 8:3 encoder (package enc_pkg).
package enc_pkg;

  localparam int ENC_VEC_W = 8;
  localparam int ENC_IDX_W = 3;
  localparam int ENC_CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

  function automatic logic [ENC_CNT_W-1:0] enc_popcount(input logic [ENC_VEC_W-1:0] v);
    logic [ENC_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENC_VEC_W; i++) begin
      c = c + ENC_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ffs_encode_8.sv
// Combinational find-first-set: index of the lowest set bit of an 8-bit vector.
module ffs_encode_8
  import enc_pkg::*;
(
  input  logic [ENC_VEC_W-1:0] vec_i,
  output logic [ENC_IDX_W-1:0] idx_o,
  output logic                 found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan high to low so the lowest set bit wins.
    for (int i = ENC_VEC_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = ENC_IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_8_3_serial.sv
// Serial 8:3 encoder: streams the index of each set request bit, lowest first.
// Optional out_cnt popcount port is enabled by defining ENCODER_COUNT_EN.
//
// state | meaning
// IDLE  | ready for a new vector, no beat pending
// DRAIN | emitting one index per accepted beat from pending_q
module encoder_8_3_serial
  import enc_pkg::*;
#(
  parameter int VEC_W = ENC_VEC_W,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
`ifdef ENCODER_COUNT_EN
  ,
  output logic [ENC_CNT_W-1:0] out_cnt
`endif
);

  enc_state_t       state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] low_idx;
  logic             low_found;
  logic             single_bit;

  ffs_encode_8 u_ffs (
    .vec_i   (pending_q),
    .idx_o   (low_idx),
    .found_o (low_found)
  );

  // Beat outputs come straight from registered state/pending; pending is zero in IDLE.
  assign single_bit = ((pending_q & (pending_q - VEC_W'(1))) == '0);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q == DRAIN);
  assign in_ready   = (state_q == IDLE);
  assign out_idx    = low_idx;
  assign out_last   = low_found && single_bit;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (in_vec != '0)) begin
          pending_d = in_vec;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << low_idx);
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef ENCODER_COUNT_EN
  logic [ENC_CNT_W-1:0] cnt_q, cnt_d;

  // Zero vectors are accepted too, so they also refresh the count.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && in_ready) begin
      cnt_d = enc_popcount(in_vec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule
